// File: rtl/line_fill_pkg.sv
// line_fill_pkg: shared types, constants and helpers for the line fill engine.
//   fill_state_t       : fill FSM states (IDLE, ISSUE, WAIT, DONE)
//   LINE_WORDS_DEFAULT : default words per cache line
//   OFFS               : word-offset width for the default line size
//   line_align()       : clears the word-offset and byte-offset bits of an address
package line_fill_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} fill_state_t;

   localparam int unsigned LINE_WORDS_DEFAULT = 16;
   localparam int unsigned OFFS = $clog2(LINE_WORDS_DEFAULT);

   // Line-aligned byte address: low (offs+2) bits forced to zero.
   function automatic logic [63:0] line_align(input logic [63:0] addr,
                                              input int unsigned offs);
      logic [63:0] mask;
      mask = ~((64'd1 << (offs + 2)) - 64'd1);
      return addr & mask;
   endfunction

endpackage

// File: rtl/line_fill_buffer.sv
// line_fill_buffer: LINE_WORDS x WORD_WIDTH line buffer.
//   clk       : clock
//   clr       : synchronous clear of every slot
//   we        : write enable
//   widx      : slot written when we=1
//   wdata     : word written
//   line_flat : slot i at bits [i*WORD_WIDTH +: WORD_WIDTH]
module line_fill_buffer #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned LINE_WORDS = 16
) (
   input  logic                             clk,
   input  logic                             clr,
   input  logic                             we,
   input  logic [$clog2(LINE_WORDS)-1:0]    widx,
   input  logic [WORD_WIDTH-1:0]            wdata,
   output logic [LINE_WORDS*WORD_WIDTH-1:0] line_flat
);

   logic [WORD_WIDTH-1:0] mem_q [LINE_WORDS];
   logic [WORD_WIDTH-1:0] mem_d [LINE_WORDS];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[widx] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int unsigned i = 0; i < LINE_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      line_flat = '0;
      for (int unsigned i = 0; i < LINE_WORDS; i++) begin
         line_flat[i*WORD_WIDTH +: WORD_WIDTH] = mem_q[i];
      end
   end

endmodule

// File: rtl/line_fill_unit.sv
// line_fill_unit: cache-line fill engine. Accepts one line request, issues
// LINE_WORDS single-word memory reads (one outstanding), assembles the line
// and presents it downstream.
//   req_*        : line request handshake (req_addr = any byte in the line)
//   mem_read_*   : word read port (address valid/ready, data valid pulse)
//   mem_addr_valid : read request valid
//   line_*       : assembled line, line-aligned byte address, valid/ready
//   crit_*       : early copy of the requested word
// Optional feature macro LINE_FILL_CRIT_FIRST_EN: fetch in wrapped order
// starting at the requested word and pulse crit_valid after the first
// word arrives. Without it fetch starts at word 0 and crit_* are tied to 0.
module line_fill_unit
   import line_fill_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LINE_WORDS = LINE_WORDS_DEFAULT
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic [ADDR_WIDTH-1:0]            req_addr,
   output logic [ADDR_WIDTH-3:0]            mem_read_addr,
   output logic                             mem_addr_valid,
   input  logic                             mem_read_ready,
   input  logic [WORD_WIDTH-1:0]            mem_read_data,
   input  logic                             mem_read_valid,
   output logic                             line_valid,
   input  logic                             line_ready,
   output logic [LINE_WORDS*WORD_WIDTH-1:0] line_data,
   output logic [ADDR_WIDTH-1:0]            line_addr,
   output logic                             crit_valid,
   output logic [WORD_WIDTH-1:0]            crit_data
);

   localparam int unsigned OFFS_W = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS_W - 2;

   fill_state_t           state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [OFFS_W-1:0]     cur_off_q, cur_off_d;
   logic [OFFS_W:0]       count_q, count_d;
   logic                  req_ready_q, req_ready_d;
   logic                  mem_addr_valid_q, mem_addr_valid_d;
   logic [ADDR_WIDTH-3:0] mem_read_addr_q, mem_read_addr_d;
   logic                  line_valid_q, line_valid_d;
   logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;

   logic [OFFS_W-1:0]     start_off;
   logic [OFFS_W-1:0]     nxt_off;
   logic                  buf_we;

`ifdef LINE_FILL_CRIT_FIRST_EN
   logic                  crit_valid_q, crit_valid_d;
   logic [WORD_WIDTH-1:0] crit_data_q, crit_data_d;
   assign start_off = req_addr[OFFS_W+1:2];
`else
   assign start_off = '0;
`endif

   // Offset arithmetic is modulo LINE_WORDS by width, giving the wrap-around.
   assign nxt_off = cur_off_q + OFFS_W'(1);

   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      cur_off_d        = cur_off_q;
      count_d          = count_q;
      req_ready_d      = req_ready_q;
      mem_addr_valid_d = mem_addr_valid_q;
      mem_read_addr_d  = mem_read_addr_q;
      line_valid_d     = line_valid_q;
      line_addr_d      = line_addr_q;
      buf_we           = 1'b0;
`ifdef LINE_FILL_CRIT_FIRST_EN
      crit_valid_d     = 1'b0;
      crit_data_d      = crit_data_q;
`endif
      unique case (state_q)
         IDLE: begin
            // req_ready is low only in the first cycle after reset.
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               idx_d            = req_addr[ADDR_WIDTH-1:OFFS_W+2];
               cur_off_d        = start_off;
               count_d          = '0;
               line_addr_d      = ADDR_WIDTH'(line_align(64'(req_addr), OFFS_W));
               req_ready_d      = 1'b0;
               mem_addr_valid_d = 1'b1;
               mem_read_addr_d  = {req_addr[ADDR_WIDTH-1:OFFS_W+2], start_off};
               state_d          = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_addr_valid_q && mem_read_ready) begin
               mem_addr_valid_d = 1'b0;
               state_d          = WAIT;
            end
         end
         WAIT: begin
            if (mem_read_valid) begin
               buf_we    = 1'b1;
               cur_off_d = nxt_off;
               count_d   = count_q + (OFFS_W+1)'(1);
`ifdef LINE_FILL_CRIT_FIRST_EN
               if (count_q == '0) begin
                  crit_valid_d = 1'b1;
                  crit_data_d  = mem_read_data;
               end
`endif
               if (count_q == (OFFS_W+1)'(LINE_WORDS - 1)) begin
                  line_valid_d = 1'b1;
                  state_d      = DONE;
               end else begin
                  mem_addr_valid_d = 1'b1;
                  mem_read_addr_d  = {idx_q, nxt_off};
                  state_d          = ISSUE;
               end
            end
         end
         DONE: begin
            if (line_ready) begin
               line_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         idx_q            <= '0;
         cur_off_q        <= '0;
         count_q          <= '0;
         req_ready_q      <= 1'b0;
         mem_addr_valid_q <= 1'b0;
         mem_read_addr_q  <= '0;
         line_valid_q     <= 1'b0;
         line_addr_q      <= '0;
`ifdef LINE_FILL_CRIT_FIRST_EN
         crit_valid_q     <= 1'b0;
         crit_data_q      <= '0;
`endif
      end else begin
         state_q          <= state_d;
         idx_q            <= idx_d;
         cur_off_q        <= cur_off_d;
         count_q          <= count_d;
         req_ready_q      <= req_ready_d;
         mem_addr_valid_q <= mem_addr_valid_d;
         mem_read_addr_q  <= mem_read_addr_d;
         line_valid_q     <= line_valid_d;
         line_addr_q      <= line_addr_d;
`ifdef LINE_FILL_CRIT_FIRST_EN
         crit_valid_q     <= crit_valid_d;
         crit_data_q      <= crit_data_d;
`endif
      end
   end

   line_fill_buffer #(
      .WORD_WIDTH (WORD_WIDTH),
      .LINE_WORDS (LINE_WORDS)
   ) u_buffer (
      .clk       (clk),
      .clr       (rst),
      .we        (buf_we),
      .widx      (cur_off_q),
      .wdata     (mem_read_data),
      .line_flat (line_data)
   );

   assign req_ready      = req_ready_q;
   assign mem_addr_valid = mem_addr_valid_q;
   assign mem_read_addr  = mem_read_addr_q;
   assign line_valid     = line_valid_q;
   assign line_addr      = line_addr_q;
`ifdef LINE_FILL_CRIT_FIRST_EN
   assign crit_valid     = crit_valid_q;
   assign crit_data      = crit_data_q;
`else
   assign crit_valid     = 1'b0;
   assign crit_data      = '0;
`endif

endmodule

// File: tb/tb_line_fill_unit.sv
// tb_line_fill_unit: self-checking bench for line_fill_unit. A behavioural
// memory (word n holds n + 0x100 + salt) and a line model built from the
// address rules drive the expected values. Honours LINE_FILL_CRIT_FIRST_EN.
module tb_line_fill_unit;

   localparam int unsigned WW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned LW = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [AW-1:0]     req_addr = '0;
   logic [AW-3:0]     mem_read_addr;
   logic              mem_addr_valid;
   logic              mem_read_ready = 1'b0;
   logic [WW-1:0]     mem_read_data = '0;
   logic              mem_read_valid = 1'b0;
   logic              line_valid;
   logic              line_ready = 1'b0;
   logic [LW*WW-1:0]  line_data;
   logic [AW-1:0]     line_addr;
   logic              crit_valid;
   logic [WW-1:0]     crit_data;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [31:0] salt = '0;
`ifdef LINE_FILL_CRIT_FIRST_EN
   localparam bit CRIT = 1'b1;
`else
   localparam bit CRIT = 1'b0;
`endif

   line_fill_unit #(
      .WORD_WIDTH (WW),
      .ADDR_WIDTH (AW),
      .LINE_WORDS (LW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .mem_read_addr  (mem_read_addr),
      .mem_addr_valid (mem_addr_valid),
      .mem_read_ready (mem_read_ready),
      .mem_read_data  (mem_read_data),
      .mem_read_valid (mem_read_valid),
      .line_valid     (line_valid),
      .line_ready     (line_ready),
      .line_data      (line_data),
      .line_addr      (line_addr),
      .crit_valid     (crit_valid),
      .crit_data      (crit_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LW*WW-1:0] obs,
                      input logic [LW*WW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] memval(input logic [29:0] n);
      return 32'(n) + 32'h100 + salt;
   endfunction

   function automatic logic [LW*WW-1:0] model_line(input logic [AW-1:0] a);
      logic [LW*WW-1:0] l;
      logic [29:0] base;
      base = a[AW-1:2] & ~30'(LW - 1);
      for (int i = 0; i < LW; i++) l[i*WW +: WW] = memval(base + 30'(i));
      return l;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, req_ready, 0);
      chk({tag, "_mem_addr_valid"}, mem_addr_valid, 0);
      chk({tag, "_mem_read_addr"}, mem_read_addr, 0);
      chk({tag, "_line_valid"}, line_valid, 0);
      chk({tag, "_line_data"}, line_data, 0);
      chk({tag, "_line_addr"}, line_addr, 0);
      chk({tag, "_crit_valid"}, crit_valid, 0);
      chk({tag, "_crit_data"}, crit_data, 0);
   endtask

   task automatic start_req(input logic [AW-1:0] a, input bit hold);
      chk("accept_ready", req_ready, 1);
      req_valid = 1'b1;
      req_addr  = a;
      tick();
      if (!hold) req_valid = 1'b0;
      chk("accept_ready_drop", req_ready, 0);
      chk("accept_issue", mem_addr_valid, 1);
   endtask

   // Serves one line from the behavioural memory and checks every step.
   task automatic fill_body(input logic [AW-1:0] a, input int stall_k,
                            input int rdy_stall, input int vld_delay,
                            input bit rand_stall, input int abort_after);
      logic [29:0] base, wa;
      int start, rs, vd;
      base  = a[AW-1:2] & ~30'(LW - 1);
      start = CRIT ? int'(a[AW-1:2] % LW) : 0;
      for (int k = 0; k < LW; k++) begin
         wa = base + 30'((start + k) % LW);
         rs = (k == stall_k) ? rdy_stall : (rand_stall ? int'($urandom_range(0, 2)) : 0);
         vd = (k == stall_k) ? vld_delay : (rand_stall ? int'($urandom_range(0, 2)) : 0);
         for (int j = 0; j < rs; j++) begin
            chk("issue_hold_valid", mem_addr_valid, 1);
            chk("issue_hold_addr", mem_read_addr, wa);
            mem_read_valid = 1'($urandom_range(0, 1));
            mem_read_data  = $urandom;
            tick();
         end
         mem_read_valid = 1'b0;
         chk("issue_valid", mem_addr_valid, 1);
         chk("issue_addr", mem_read_addr, wa);
         mem_read_ready = 1'b1;
         tick();
         mem_read_ready = 1'b0;
         chk("issue_drop", mem_addr_valid, 0);
         if (abort_after == k) return;
         for (int j = 0; j < vd; j++) begin
            tick();
            chk("wait_no_dup", mem_addr_valid, 0);
         end
         mem_read_valid = 1'b1;
         mem_read_data  = memval(wa);
         tick();
         mem_read_valid = 1'b0;
         mem_read_data  = $urandom;
         chk("crit_valid", crit_valid, (CRIT && k == 0) ? 1 : 0);
         if (CRIT && k == 0) chk("crit_data", crit_data, memval(a[AW-1:2]));
         if (!CRIT) chk("crit_data_tied", crit_data, 0);
         if (k < LW - 1) chk("line_valid_early", line_valid, 0);
      end
      chk("line_valid", line_valid, 1);
      chk("line_data", line_data, model_line(a));
      chk("line_addr", line_addr, a & ~32'(LW * 4 - 1));
   endtask

   task automatic drain();
      line_ready = 1'b1;
      tick();
      line_ready = 1'b0;
      chk("drain_line_valid", line_valid, 0);
      chk("drain_req_ready", req_ready, 1);
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [LW*WW-1:0] basic_line;

      // reset state
      tick();
      tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();
      chk("reset_req_ready", req_ready, 1);

      // basic fill: 0x40 -> words 0x110.. 0x11F
      salt = 32'h0;
      start_req(32'h0000_0040, 1'b0);
      fill_body(32'h0000_0040, -1, 0, 0, 1'b0, -1);
      basic_line = model_line(32'h0000_0040);
      chk("basic_word0", line_data[WW-1:0], 32'h110);
      chk("basic_word15", line_data[15*WW +: WW], 32'h11F);

      // backpressure: line held, requests and stray read data ignored
      req_valid = 1'b1;
      req_addr  = 32'h0000_8000;
      for (int c = 0; c < 10; c++) begin
         mem_read_valid = 1'($urandom_range(0, 1));
         mem_read_data  = $urandom;
         tick();
         chk("bp_line_valid", line_valid, 1);
         chk("bp_line_data", line_data, basic_line);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_no_issue", mem_addr_valid, 0);
      end
      req_valid = 1'b0;
      mem_read_valid = 1'b0;
      drain();

      // critical-word request: same line, layout identical to basic fill
      start_req(32'h0000_004C, 1'b0);
      fill_body(32'h0000_004C, -1, 0, 0, 1'b0, -1);
      chk("crit_layout", line_data, basic_line);
      drain();

      // memory stall: 7 cycles not ready, data 4 cycles late
      salt = $urandom;
      a = $urandom;
      start_req(a, 1'b0);
      fill_body(a, 0, 7, 4, 1'b0, -1);
      drain();

      // randomized fills with random stalls
      for (int n = 0; n < 6; n++) begin
         salt = $urandom;
         a = $urandom;
         start_req(a, 1'b0);
         fill_body(a, -1, 0, 0, 1'b1, -1);
         drain();
      end

      // reset mid-fill after 5 words, then a late read-data pulse
      salt = $urandom;
      a = $urandom;
      start_req(a, 1'b0);
      fill_body(a, -1, 0, 0, 1'b0, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_all_zero("midreset");
      tick();
      chk("midreset_req_ready", req_ready, 1);
      mem_read_valid = 1'b1;
      mem_read_data  = 32'hDEAD_BEEF;
      tick();
      mem_read_valid = 1'b0;
      chk("late_data_line", line_data, 0);
      chk("late_data_issue", mem_addr_valid, 0);
      chk("late_data_ready", req_ready, 1);

      // back-to-back: req_valid held high across two fills
      salt = 32'h1000;
      a = 32'h0000_1230;
      start_req(a, 1'b1);
      fill_body(a, -1, 0, 0, 1'b1, -1);
      a = 32'h0000_2004;
      req_addr   = a;
      line_ready = 1'b1;
      tick();
      line_ready = 1'b0;
      chk("b2b_line_drop", line_valid, 0);
      chk("b2b_ready_rise", req_ready, 1);
      tick();
      req_valid = 1'b0;
      chk("b2b_accept", req_ready, 0);
      chk("b2b_issue", mem_addr_valid, 1);
      salt = 32'h5000;
      fill_body(a, -1, 0, 0, 1'b1, -1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
